fetch_decode_buffer: RTL

//  Per-thread instruction queue between fetch_top and the decode stage. Absorbs fetch

---
 rtl/fetch_decode_buffer_pkg.sv | 27 ++
 rtl/fetch_decode_buffer_if.sv | 37 +++
 rtl/fetch_decode_buffer_fifo.sv | 68 ++++++
 rtl/fetch_decode_buffer.sv | 95 +++++++++
 4 files changed

// File: rtl/fetch_decode_buffer_pkg.sv
// Shared types and defaults for the per-thread fetch-to-decode instruction buffer.
package fetch_decode_buffer_pkg;

    localparam int THR_PER_CORE = 2;
    localparam int INSTR_WIDTH  = 32;
    localparam int PC_WIDTH     = 32;
    localparam int FBUF_DEPTH   = 4;
    localparam int FBUF_SKID    = 2;

    // Fetch-side fault information travelling alongside each instruction.
    typedef struct packed {
        logic xcpt_itlb_miss;
        logic xcpt_bus_err;
    } fetch_xcpt_t;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]    pc;
        fetch_xcpt_t            xcpt;
    } fetch_buf_entry_t;

    // Thread-id width, kept at least one bit so single-thread builds stay legal.
    function automatic int thr_id_width(input int thr);
        return (thr > 1) ? $clog2(thr) : 1;
    endfunction

endpackage

// File: rtl/fetch_decode_buffer_if.sv
// Fetch-to-decode buffer bus: fetch delivery and per-thread controls in, decode presentation out.
interface fetch_decode_buffer_if #(
    parameter int THR = fetch_decode_buffer_pkg::THR_PER_CORE
);
    import fetch_decode_buffer_pkg::*;

    localparam int TW = thr_id_width(THR);

    logic                   in_valid;
    logic [INSTR_WIDTH-1:0] in_instr;
    logic [PC_WIDTH-1:0]    in_pc;
    logic [TW-1:0]          in_thread_id;
    fetch_xcpt_t            in_xcpt;
    logic [THR-1:0]         flush;
    logic [THR-1:0]         dec_stall;

    logic [THR-1:0]         stall_fetch;
    logic                   dec_valid;
    logic [INSTR_WIDTH-1:0] dec_instr;
    logic [PC_WIDTH-1:0]    dec_pc;
    logic [TW-1:0]          dec_thread_id;
    fetch_xcpt_t            dec_xcpt;
    logic                   ovf_error;

    // Fetch/decode environment side.
    modport master (
        output in_valid, in_instr, in_pc, in_thread_id, in_xcpt, flush, dec_stall,
        input  stall_fetch, dec_valid, dec_instr, dec_pc, dec_thread_id, dec_xcpt, ovf_error
    );

    // Buffer side.
    modport slave (
        input  in_valid, in_instr, in_pc, in_thread_id, in_xcpt, flush, dec_stall,
        output stall_fetch, dec_valid, dec_instr, dec_pc, dec_thread_id, dec_xcpt, ovf_error
    );

endinterface

// File: rtl/fetch_decode_buffer_fifo.sv
// Single-thread instruction FIFO: same-cycle push/pop, flush to empty, drop reporting when full.
module fetch_decode_buffer_fifo
    import fetch_decode_buffer_pkg::*;
#(
    parameter  int DEPTH = FBUF_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_buf_entry_t wr_data,
    output fetch_buf_entry_t head,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    count_next,
    output logic             dropped
);

    fetch_buf_entry_t mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && (count != '0) && !flush;
    // A full queue still takes a push in the cycle it also pops.
    assign do_push = push && !flush && (!full || do_pop);
    assign dropped = push && !flush && !do_push;
    assign head    = mem[rd_ptr];

    // NOTE: every output of a combinational block gets a default first, so no latch can form.
    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (do_push && !do_pop)
            count_next = count + 1'b1;
        else if (do_pop && !do_push)
            count_next = count - 1'b1;
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; count alone decides validity, so stale words are never presented.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fetch_decode_buffer.sv
// Per-thread fetch queues feeding decode: round-robin thread pick, flush, and fetch backpressure.
module fetch_decode_buffer
    import fetch_decode_buffer_pkg::*;
#(
    parameter int THR   = THR_PER_CORE,
    parameter int DEPTH = FBUF_DEPTH,
    parameter int SKID  = FBUF_SKID
) (
    input logic                  clock,
    input logic                  reset,
    fetch_decode_buffer_if.slave bus
);

    localparam int TW = thr_id_width(THR);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_buf_entry_t wr_data;
    fetch_buf_entry_t head       [THR];
    logic [CW-1:0]    count      [THR];
    logic [CW-1:0]    count_next [THR];
    logic [THR-1:0]   push_sel;
    logic [THR-1:0]   pop_sel;
    logic [THR-1:0]   eligible;
    logic [THR-1:0]   dropped;
    logic [THR-1:0]   stall_next;
    logic [THR-1:0]   stall_q;
    logic             ovf_q;
    logic [TW-1:0]    rr_ptr;
    logic [TW-1:0]    sel;
    logic             found;

    assign wr_data = '{instr: bus.in_instr, pc: bus.in_pc, xcpt: bus.in_xcpt};

    for (genvar t = 0; t < THR; t++) begin : g_thr
        assign push_sel[t]   = bus.in_valid && (bus.in_thread_id == TW'(t));
        assign eligible[t]   = (count[t] != '0) && !bus.dec_stall[t] && !bus.flush[t];
        // Leave SKID slots free for responses fetch already has in flight.
        assign stall_next[t] = (DEPTH - int'(count_next[t])) <= SKID;

        fetch_decode_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clock      (clock),
            .reset      (reset),
            .push       (push_sel[t]),
            .pop        (pop_sel[t]),
            .flush      (bus.flush[t]),
            .wr_data    (wr_data),
            .head       (head[t]),
            .count      (count[t]),
            .count_next (count_next[t]),
            .dropped    (dropped[t])
        );
    end

    // Round-robin: first eligible thread at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        sel   = rr_ptr;
        found = 1'b0;
        for (int off = 0; off < THR; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= THR) idx = idx - THR;
            if (!found && eligible[TW'(idx)]) begin
                sel   = TW'(idx);
                found = 1'b1;
            end
        end
    end

    // Decode is committed to accept whatever is presented, so pop on present.
    assign pop_sel = found ? (THR'(1) << sel) : '0;

    assign bus.dec_valid     = found;
    assign bus.dec_instr     = head[sel].instr;
    assign bus.dec_pc        = head[sel].pc;
    assign bus.dec_xcpt      = head[sel].xcpt;
    assign bus.dec_thread_id = sel;
    assign bus.stall_fetch   = stall_q;
    assign bus.ovf_error     = ovf_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr  <= '0;
            stall_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (found)
                rr_ptr <= (int'(sel) == THR - 1) ? '0 : sel + 1'b1;
            stall_q <= stall_next;
            if (|dropped)
                ovf_q <= 1'b1;
        end
    end

endmodule
